// File: rtl/ieee_normalize_pack.sv
// Output end of the single-precision adder path: takes the raw significand
// sum, normalizes it one shift per clock, rounds to nearest-even and packs
// the IEEE-754 word behind a valid/ready handshake.
module ieee_normalize_pack #(
  parameter int EXPO_LEN  = 8,
  parameter int FRAC_LEN  = 23,
  parameter int GUARDBITS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sign,
  input  logic [EXPO_LEN-1:0]              in_exponent,
  input  logic [FRAC_LEN+GUARDBITS+1:0]    in_significand,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXPO_LEN+FRAC_LEN:0]       out_result,
  output logic                             out_overflow,
  output logic                             out_inexact
);

  // Significand layout: {carry, hidden, fraction, G, R, S...}
  localparam int SIG_W      = FRAC_LEN + GUARDBITS + 2;
  localparam int EXP_W      = EXPO_LEN + 1;
  localparam int MANT_W     = FRAC_LEN + 1;
  localparam int CARRY_BIT  = SIG_W - 1;
  localparam int HIDDEN_BIT = SIG_W - 2;

  // The exponent is tracked one bit wider so that reaching all-ones
  // (or beyond) is visible as overflow rather than wrapping.
  localparam logic [EXP_W-1:0] EXP_MAX  = {1'b0, {EXPO_LEN{1'b1}}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t                      state_q, state_d;
  logic                        sign_q, sign_d;
  logic [EXP_W-1:0]            exp_q, exp_d;
  logic [SIG_W-1:0]            sig_q, sig_d;
  logic [EXPO_LEN+FRAC_LEN:0]  result_q, result_d;
  logic                        overflow_q, overflow_d;
  logic                        inexact_q, inexact_d;

  // Shift helpers: right shift keeps the dropped bit alive in the sticky
  // position so rounding still sees it; left shift fills with zero.
  logic [EXP_W-1:0] expInc;
  logic [EXP_W-1:0] expDec;
  logic [SIG_W-1:0] sigRight;
  logic [SIG_W-1:0] sigLeft;
  logic             carryBit;
  logic             hiddenBit;

  // Rounding helpers (nearest-even on the hidden+fraction mantissa).
  logic              guardBit;
  logic              roundBit;
  logic              stickyBit;
  logic              roundUp;
  logic [MANT_W:0]   mantSum;
  logic [FRAC_LEN-1:0] fracRounded;
  logic [EXP_W-1:0]  expRounded;

  // Sign-preserving infinity used by every overflow path.
  logic [EXPO_LEN+FRAC_LEN:0] infWord;

  // Shift and round datapath derived from the working registers.
  always_comb begin
    expInc    = exp_q + EXP_ONE;
    expDec    = exp_q - EXP_ONE;
    carryBit  = sig_q[CARRY_BIT];
    hiddenBit = sig_q[HIDDEN_BIT];
    sigRight  = {1'b0, sig_q[SIG_W-1:1]} | {{(SIG_W-1){1'b0}}, sig_q[0]};
    sigLeft   = {sig_q[SIG_W-2:0], 1'b0};

    guardBit  = sig_q[GUARDBITS-1];
    roundBit  = sig_q[GUARDBITS-2];
    stickyBit = |sig_q[GUARDBITS-3:0];
    roundUp   = guardBit & (roundBit | stickyBit | sig_q[GUARDBITS]);
    mantSum   = {1'b0, sig_q[HIDDEN_BIT:GUARDBITS]} + {{MANT_W{1'b0}}, roundUp};

    if (mantSum[MANT_W]) begin
      fracRounded = mantSum[FRAC_LEN:1];
      expRounded  = expInc;
    end else begin
      fracRounded = mantSum[FRAC_LEN-1:0];
      if (exp_q == EXP_ZERO && mantSum[MANT_W-1]) begin
        expRounded = EXP_ONE;
      end else begin
        expRounded = exp_q;
      end
    end

    infWord = {sign_q, {EXPO_LEN{1'b1}}, {FRAC_LEN{1'b0}}};
  end

  // Next-state logic: capture, one normalization action per SHIFT cycle,
  // round-and-pack, then hold the result until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d     = in_sign;
          exp_d      = {1'b0, in_exponent};
          sig_d      = in_significand;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (exp_q == EXP_MAX) begin
          // Inf/NaN pass through with their fraction bits untouched.
          result_d   = {sign_q, exp_q[EXPO_LEN-1:0], sig_q[GUARDBITS +: FRAC_LEN]};
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          state_d    = DONE;
        end else if (sig_q == '0) begin
          result_d   = {sign_q, {(EXPO_LEN+FRAC_LEN){1'b0}}};
          inexact_d  = 1'b0;
          state_d    = DONE;
        end else if (carryBit) begin
          sig_d = sigRight;
          exp_d = expInc;
          if (expInc >= EXP_MAX) begin
            result_d   = infWord;
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
            state_d    = DONE;
          end
        end else if (exp_q == EXP_ZERO && hiddenBit) begin
          exp_d   = EXP_ONE;
          state_d = ROUND;
        end else if (!hiddenBit && exp_q > EXP_ONE) begin
          sig_d = sigLeft;
          exp_d = expDec;
        end else if (!hiddenBit) begin
          exp_d   = EXP_ZERO;
          state_d = ROUND;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        inexact_d = guardBit | roundBit | stickyBit;
        if (expRounded >= EXP_MAX) begin
          result_d   = infWord;
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          result_d = {sign_q, expRounded[EXPO_LEN-1:0], fracRounded};
        end
        exp_d   = expRounded;
        state_d = DONE;
      end

      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
    end
  end

  // Handshake outputs are forced quiet for every cycle reset is asserted.
  always_comb begin
    in_ready     = (state_q == IDLE) && !rst;
    out_valid    = (state_q == DONE) && !rst;
    out_result   = rst ? '0 : result_q;
    out_overflow = rst ? 1'b0 : overflow_q;
    out_inexact  = rst ? 1'b0 : inexact_q;
  end

endmodule

// File: tb/tb_ieee_normalize_pack.sv
// Self-checking bench for ieee_normalize_pack: directed vector table,
// hand-written stall and reset-abort sequences, then randomized sums
// compared against an arithmetic reference model.
module tb_ieee_normalize_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [27:0] in_significand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_inexact;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  ieee_normalize_pack #(
    .EXPO_LEN (8),
    .FRAC_LEN (23),
    .GUARDBITS(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_significand(in_significand),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_inexact   (out_inexact)
  );

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [27:0] sig;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Build {carry, hidden, frac, GRS}.
  function automatic logic [27:0] mkSig(input logic c, input logic h,
                                        input logic [22:0] f, input logic [2:0] grs);
    return {c, h, f, grs};
  endfunction

  // Reference model: value-level normalize and nearest-even rounding,
  // with the latency in cycles from the accept edge.
  function automatic void refModel(input logic s, input logic [7:0] e, input logic [27:0] sig,
                                   output logic [31:0] res, output logic ovf,
                                   output logic inx, output int lat);
    longint unsigned m, mant, rem;
    int ex, cyc;
    logic up;
    ovf = 1'b0; inx = 1'b0; m = sig; ex = e; cyc = 1;
    if (e == 8'hFF) begin
      res = {s, 8'hFF, sig[25:3]}; lat = 2; return;
    end
    if (m == 0) begin
      res = {s, 31'b0}; lat = 2; return;
    end
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 64'd1);
      ex++; cyc++;
      if (ex >= 255) begin
        res = {s, 8'hFF, 23'b0}; ovf = 1'b1; inx = 1'b1; lat = cyc; return;
      end
    end
    while (m < (64'd1 << 26) && ex > 1) begin
      m = m << 1; ex--; cyc++;
    end
    if (m < (64'd1 << 26)) ex = 0;
    else if (ex == 0) ex = 1;
    cyc++;
    mant = m >> 3;
    rem  = m & 64'd7;
    inx  = (rem != 0);
    up   = (rem > 4) || (rem == 4 && (mant & 64'd1) == 1);
    mant = mant + (up ? 64'd1 : 64'd0);
    if (mant >= (64'd1 << 24)) begin
      mant = mant >> 1; ex++;
    end else if (ex == 0 && mant >= (64'd1 << 23)) begin
      ex = 1;
    end
    cyc++;
    if (ex >= 255) begin
      res = {s, 8'hFF, 23'b0}; ovf = 1'b1; inx = 1'b1;
    end else begin
      res = {s, 8'(ex), 23'(mant)};
    end
    lat = cyc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one sum, then count negedges until out_valid (cycle k after the
  // accept edge is the value a consumer samples at edge T+k).
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] sig,
                               output int lat, output bit timedOut);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    timedOut = !in_ready;
    lat = 0;
    if (timedOut) return;
    in_valid = 1'b1; in_sign = s; in_exponent = e; in_significand = sig;
    @(posedge clk);
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    timedOut = !out_valid;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runCheck(input string name, input logic s, input logic [7:0] e,
                          input logic [27:0] sig, input logic [31:0] res,
                          input logic ovf, input logic inx, input int lat);
    int  gotLat;
    bit  timedOut;
    applyStimulus(s, e, sig, gotLat, timedOut);
    checkOutput({name, " timeout"}, 32'(timedOut), 32'd0);
    if (!timedOut) begin
      checkOutput({name, " result"}, out_result, res);
      checkOutput({name, " overflow"}, 32'(out_overflow), 32'(ovf));
      checkOutput({name, " inexact"}, 32'(out_inexact), 32'(inx));
      checkOutput({name, " latency"}, 32'(gotLat), 32'(lat));
      releaseResult();
    end
  endtask

  initial begin
    logic [31:0] mRes;
    logic        mOvf, mInx;
    int          mLat;
    logic        rs;
    logic [7:0]  re;
    logic [27:0] rsig;
    bit          sawValid;

    vecs[0]  = '{"normal",      1'b0, 8'h7F, mkSig(0,1,23'h000000,3'b000), 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[1]  = '{"carry",       1'b0, 8'h7F, mkSig(1,1,23'h000000,3'b000), 32'h40400000, 1'b0, 1'b0, 4};
    vecs[2]  = '{"cancel",      1'b0, 8'h7F, mkSig(0,0,23'h200000,3'b000), 32'h3E800000, 1'b0, 1'b0, 5};
    vecs[3]  = '{"denormal",    1'b0, 8'h01, mkSig(0,0,23'h400000,3'b000), 32'h00400000, 1'b0, 1'b0, 3};
    vecs[4]  = '{"tie odd",     1'b0, 8'h7F, mkSig(0,1,23'h000001,3'b100), 32'h3F800002, 1'b0, 1'b1, 3};
    vecs[5]  = '{"tie even",    1'b0, 8'h7F, mkSig(0,1,23'h000000,3'b100), 32'h3F800000, 1'b0, 1'b1, 3};
    vecs[6]  = '{"round carry", 1'b0, 8'h7F, mkSig(0,1,23'h7FFFFF,3'b110), 32'h40000000, 1'b0, 1'b1, 3};
    vecs[7]  = '{"shift ovf",   1'b0, 8'hFE, mkSig(1,1,23'h000000,3'b000), 32'h7F800000, 1'b1, 1'b1, 2};
    vecs[8]  = '{"neg zero",    1'b1, 8'h50, 28'h0,                        32'h80000000, 1'b0, 1'b0, 2};
    vecs[9]  = '{"nan",         1'b0, 8'hFF, mkSig(0,0,23'h000001,3'b000), 32'h7F800001, 1'b0, 1'b0, 2};
    vecs[10] = '{"round ovf",   1'b0, 8'hFE, mkSig(0,1,23'h7FFFFF,3'b110), 32'h7F800000, 1'b1, 1'b1, 3};
    vecs[11] = '{"denorm grow", 1'b0, 8'h00, mkSig(0,1,23'h000000,3'b000), 32'h00800000, 1'b0, 1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exponent = '0; in_significand = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_result", out_result, 32'd0);
    checkOutput("reset flags", {30'd0, out_overflow, out_inexact}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      runCheck(vecs[i].name, vecs[i].s, vecs[i].e, vecs[i].sig,
               vecs[i].res, vecs[i].ovf, vecs[i].inx, vecs[i].lat);
    end

    // Stall: result and flags hold while the consumer is not ready.
    begin
      int  gotLat;
      bit  timedOut;
      applyStimulus(1'b0, 8'h7F, mkSig(0,1,23'h000001,3'b100), gotLat, timedOut);
      checkOutput("stall timeout", 32'(timedOut), 32'd0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("stall valid", 32'(out_valid), 32'd1);
        checkOutput("stall result", out_result, 32'h3F800002);
        checkOutput("stall flags", {30'd0, out_overflow, out_inexact}, 32'd1);
        checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      end
      releaseResult();
    end

    // Reset pulse while a cancellation sum is still shifting.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exponent = 8'h7F;
    in_significand = mkSig(0,0,23'h200000,3'b000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abort rst in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort rst out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort in_ready after", 32'(in_ready), 32'd1);
    sawValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort no valid", 32'(sawValid), 32'd0);
    runCheck("after abort", vecs[0].s, vecs[0].e, vecs[0].sig,
             vecs[0].res, vecs[0].ovf, vecs[0].inx, vecs[0].lat);

    // Randomized sums against the reference model.
    for (int n = 0; n < 200; n++) begin
      int eSel, sh;
      rs   = 1'($urandom);
      eSel = $urandom_range(0, 9);
      case (eSel)
        0: re = 8'h00;
        1: re = 8'h01;
        2: re = 8'hFE;
        3: re = 8'hFF;
        4: re = 8'hFD;
        default: re = 8'($urandom_range(1, 254));
      endcase
      sh = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 30);
      rsig = 28'($urandom) >> sh;
      refModel(rs, re, rsig, mRes, mOvf, mInx, mLat);
      runCheck("random", rs, re, rsig, mRes, mOvf, mInx, mLat);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
